adc_capture_mc: RTL and testbench
=================================

ADC_CAPTURE_MC -- requirements
Module: adc_capture_mc

Interface
REQ-001 Parameter CH_NUM, default 2, number of ADC channels (1..8).
REQ-002 Parameter DATA_W, default 14, ADC sample width per channel.
REQ-003 Parameter DEC_MAX_LOG2, default 4, maximum decimation exponent (window up to 2^DEC_MAX_LOG2 samples).
REQ-004 sys_clk  in  1  single clock; all logic rising-edge.
REQ-005 sys_rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  capture enable; a 0->1 edge starts a new window.
REQ-007 fmt_twos  in  1  1 = convert offset-binary input to two's complement (invert MSB), 0 = pass unsigned.
REQ-008 dec_log2  in  3  decimation exponent; window = 2^dec_log2 samples.
REQ-009 ad_data  in  CH_NUM*DATA_W  packed samples, channel 0 in LSBs.
REQ-010 ad_of  in  CH_NUM  per-channel ADC out-of-range flag.
REQ-011 of_clr  in  1  single-cycle clear of of_sticky and overflow.
REQ-012 m_data  out  CH_NUM*DATA_W  decimated/averaged samples, same packing.
REQ-013 m_of  out  CH_NUM  OR of ad_of over the window that produced m_data.
REQ-014 m_valid  out  1  m_data/m_of valid.
REQ-015 m_ready  in  1  downstream accept.
REQ-016 of_sticky  out  CH_NUM  per-channel sticky out-of-range flag.
REQ-017 overflow  out  1  sticky flag: a result was dropped.

Function
REQ-018 ad_data/ad_of SHALL be registered in an input stage every cycle regardless of en.
REQ-019 Format conversion SHALL be applied to the registered sample; fmt_twos sampled with dec_log2 at window start.
REQ-020 dec_log2 and fmt_twos SHALL be latched on en 0->1 and at each window completion; values of dec_log2 > DEC_MAX_LOG2 SHALL clamp to DEC_MAX_LOG2.
REQ-021 Per channel, an accumulator of DATA_W+DEC_MAX_LOG2 bits SHALL sum converted samples; signed when fmt_twos=1, unsigned otherwise; no overflow possible by width.
REQ-022 A window counter SHALL count accepted samples 0..2^dec_log2-1; on the last sample, result = (acc + sample) shifted right by dec_log2 (arithmetic if signed, logical if unsigned), truncated to DATA_W; accumulators and window OR-flag SHALL restart from the next sample with no lost cycle.
REQ-023 Latency: sample presented at edge k SHALL complete a window at edge k+1 and appear on m_data with m_valid=1 after edge k+2.
REQ-024 With dec_log2=0 the block SHALL produce one output per input sample (pure pipeline).
REQ-025 Handshake: transfer occurs when m_valid && m_ready; m_data/m_of SHALL hold stable while m_valid && !m_ready.
REQ-026 Result with output empty or transferring same cycle SHALL load output; result while m_valid && !m_ready SHALL be dropped (held data kept) and overflow set.
REQ-027 en=0: accumulators and counter SHALL clear and hold; pending output SHALL remain until accepted; a window in progress when en falls SHALL be discarded.
REQ-028 of_sticky[i] SHALL set when registered ad_of[i]=1 (any en); of_clr SHALL clear of_sticky and overflow; set in same cycle as of_clr SHALL win.

Reset
REQ-029 On sys_rst=1, asynchronously: m_data=0, m_of=0, m_valid=0, of_sticky=0, overflow=0, accumulators/counters/input regs=0, latched dec_log2=0, fmt_twos latch=0.
REQ-030 First window after reset release SHALL start on the first en=1 cycle (en high during reset counts as a rising edge).

Verification
REQ-031 CH_NUM=2, dec_log2=0, fmt_twos=0, m_ready=1, ad_data ch0=0x1234 at edge k -> m_data ch0=0x1234, m_valid=1 after edge k+2.
REQ-032 dec_log2=2, fmt_twos=1, ch0 samples 0x2000,0x2004,0x2008,0x200C -> one output ch0=0x0006 (signed mean), exactly one m_valid per 4 samples.
REQ-033 dec_log2=1, fmt_twos=1, ch1 samples 0x0000,0x0002 (-8192,-8190) -> ch1 = 0x2001 (-8191, arithmetic shift).
REQ-034 m_ready=0 for 3 windows at dec_log2=0 -> first result held stable, overflow=1, later results dropped; of_clr -> overflow=0.
REQ-035 ad_of[1] pulse one cycle mid-window, dec_log2=3 -> m_of[1]=1 on that window only, of_sticky[1]=1 until of_clr.
REQ-036 sys_rst asserted mid-window with m_valid=1 -> all outputs 0 immediately; after release first output needs a full new window.

Source files
------------

// File: rtl/adc_capture_mc.sv
// Multi-channel ADC capture: input register, optional offset-binary to
// two's complement conversion, power-of-two window averaging, valid/ready out.
module adc_capture_mc #(
  parameter int CH_NUM       = 2,
  parameter int DATA_W       = 14,
  parameter int DEC_MAX_LOG2 = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     en,
  input  logic                     fmt_twos,
  input  logic [2:0]               dec_log2,
  input  logic [CH_NUM*DATA_W-1:0] ad_data,
  input  logic [CH_NUM-1:0]        ad_of,
  input  logic                     of_clr,
  output logic [CH_NUM*DATA_W-1:0] m_data,
  output logic [CH_NUM-1:0]        m_of,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CH_NUM-1:0]        of_sticky,
  output logic                     overflow
);

  localparam int AW = DATA_W + DEC_MAX_LOG2;
  localparam int CW = (DEC_MAX_LOG2 > 0) ? DEC_MAX_LOG2 : 1;
  localparam logic [DATA_W-1:0] MSB_M = DATA_W'(1) << (DATA_W - 1);

  // input stage
  logic [CH_NUM*DATA_W-1:0] d_r;
  logic [CH_NUM-1:0]        of_r;
  logic                     en_r;
  logic                     en_q;
  logic                     fmt_r;
  logic [2:0]               dec_r;

  // window state
  logic [2:0]        dec_q;
  logic              fmt_q;
  logic [AW-1:0]     acc [CH_NUM];
  logic [CW-1:0]     cnt;
  logic [CH_NUM-1:0] win_of;

  // result stage
  logic [CH_NUM*DATA_W-1:0] res_data;
  logic [CH_NUM-1:0]        res_of;
  logic                     res_valid;

  // combinational window math
  logic                     start;
  logic [2:0]               dec_c;
  logic [2:0]               dec_e;
  logic                     fmt_e;
  logic [CW:0]              lim;
  logic                     last;
  logic [DATA_W-1:0]        smp   [CH_NUM];
  logic [AW-1:0]            ext   [CH_NUM];
  logic [AW-1:0]            sum   [CH_NUM];
  logic signed [AW-1:0]     sum_s [CH_NUM];
  logic [CH_NUM*DATA_W-1:0] res_n;

  // output handshake
  logic take;
  logic load;
  logic drop;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      d_r   <= '0;
      of_r  <= '0;
      en_r  <= 1'b0;
      en_q  <= 1'b0;
      fmt_r <= 1'b0;
      dec_r <= '0;
    end else begin
      d_r   <= ad_data;
      of_r  <= ad_of;
      en_r  <= en;
      en_q  <= en_r;
      fmt_r <= fmt_twos;
      dec_r <= dec_log2;
    end
  end

  always_comb begin
    start = en_r && !en_q;
    dec_c = (32'(dec_r) > DEC_MAX_LOG2) ? 3'(DEC_MAX_LOG2) : dec_r;
    dec_e = start ? dec_c : dec_q;
    fmt_e = start ? fmt_r : fmt_q;
    lim   = ((CW+1)'(1) << dec_e) - (CW+1)'(1);
    last  = ({1'b0, cnt} == lim);
    res_n = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      smp[c]   = d_r[c*DATA_W +: DATA_W] ^ (fmt_e ? MSB_M : '0);
      ext[c]   = '0;
      if (fmt_e) ext[c] = AW'(signed'(smp[c]));
      else       ext[c] = AW'(smp[c]);
      sum[c]   = acc[c] + ext[c];
      sum_s[c] = sum[c];
      // signed data needs an arithmetic shift to round toward -inf
      if (fmt_e) res_n[c*DATA_W +: DATA_W] = DATA_W'(sum_s[c] >>> dec_e);
      else       res_n[c*DATA_W +: DATA_W] = DATA_W'(sum[c] >> dec_e);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dec_q     <= '0;
      fmt_q     <= 1'b0;
      cnt       <= '0;
      win_of    <= '0;
      res_data  <= '0;
      res_of    <= '0;
      res_valid <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) acc[c] <= '0;
    end else if (!en_r) begin
      cnt       <= '0;
      win_of    <= '0;
      res_valid <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) acc[c] <= '0;
    end else if (last) begin
      // close the window and pick up config for the next one
      dec_q     <= dec_c;
      fmt_q     <= fmt_r;
      cnt       <= '0;
      win_of    <= '0;
      res_data  <= res_n;
      res_of    <= win_of | of_r;
      res_valid <= 1'b1;
      for (int c = 0; c < CH_NUM; c++) acc[c] <= '0;
    end else begin
      if (start) begin
        dec_q <= dec_c;
        fmt_q <= fmt_r;
      end
      cnt       <= cnt + CW'(1);
      win_of    <= win_of | of_r;
      res_valid <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) acc[c] <= sum[c];
    end
  end

  always_comb begin
    take = m_valid && m_ready;
    load = res_valid && (!m_valid || m_ready);
    drop = res_valid && m_valid && !m_ready;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_data    <= '0;
      m_of      <= '0;
      m_valid   <= 1'b0;
      overflow  <= 1'b0;
      of_sticky <= '0;
    end else begin
      if (load) begin
        m_data  <= res_data;
        m_of    <= res_of;
        m_valid <= 1'b1;
      end else if (take) begin
        m_valid <= 1'b0;
      end
      // a new event in the clearing cycle survives the clear
      overflow  <= of_clr ? drop : (overflow | drop);
      of_sticky <= of_clr ? of_r : (of_sticky | of_r);
    end
  end

endmodule

// File: tb/tb_adc_capture_mc.sv
// Bench for adc_capture_mc: window vectors checked through a scoreboard,
// plus hand sequences for latency, backpressure, flags and reset.
module tb_adc_capture_mc;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic        fmt_twos;
  logic [2:0]  dec_log2;
  logic [27:0] ad_data;
  logic [1:0]  ad_of;
  logic        of_clr;
  logic [27:0] m_data;
  logic [1:0]  m_of;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  of_sticky;
  logic        overflow;

  adc_capture_mc #(.CH_NUM(2), .DATA_W(14), .DEC_MAX_LOG2(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .fmt_twos(fmt_twos),
    .dec_log2(dec_log2), .ad_data(ad_data), .ad_of(ad_of), .of_clr(of_clr),
    .m_data(m_data), .m_of(m_of), .m_valid(m_valid), .m_ready(m_ready),
    .of_sticky(of_sticky), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0]  d;
    logic        f;
    logic [13:0] b0, s0, b1, s1, e0, e1;
  } vec_t;

  typedef struct {
    logic [27:0] data;
    logic [1:0]  of;
  } exp_t;

  vec_t tbl [7];
  exp_t q [$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // one cycle; scoreboard compares each transfer seen
  task automatic step();
    exp_t e;
    @(negedge sys_clk);
    if (mon_en && m_valid && m_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h want none", m_data);
      end else begin
        e = q.pop_front();
        if (m_data !== e.data || m_of !== e.of) begin
          errors++;
          $display("FAIL sb_out got %h/%b want %h/%b",
                   m_data, m_of, e.data, e.of);
        end
      end
    end
  endtask

  task automatic drive_window(input logic [2:0] d, input logic f,
                              input logic [13:0] b0, input logic [13:0] s0,
                              input logic [13:0] b1, input logic [13:0] s1,
                              input int of_at, input logic [1:0] ofv);
    int n;
    logic [13:0] v0, v1;
    n = 1 << ((d > 3'd4) ? 4 : int'(d));
    for (int i = 0; i < n; i++) begin
      step();
      v0 = b0 + s0 * 14'(i);
      v1 = b1 + s1 * 14'(i);
      en = 1'b1; dec_log2 = d; fmt_twos = f;
      ad_data = {v1, v0};
      ad_of = (i == of_at) ? ofv : 2'b00;
    end
    step();
    en = 1'b0; ad_of = 2'b00;
    repeat (3) step();
  endtask

  initial begin
    tbl[0] = '{3'd0, 1'b0, 14'h1234, 14'h0, 14'h0ABC, 14'h0, 14'h1234, 14'h0ABC};
    tbl[1] = '{3'd2, 1'b1, 14'h2000, 14'h4, 14'h1FFF, 14'h0, 14'h0006, 14'h3FFF};
    tbl[2] = '{3'd1, 1'b1, 14'h3FFF, 14'h0, 14'h0000, 14'h2, 14'h1FFF, 14'h2001};
    tbl[3] = '{3'd3, 1'b0, 14'h3FFF, 14'h0, 14'h0000, 14'h1, 14'h3FFF, 14'h0003};
    tbl[4] = '{3'd1, 1'b0, 14'h0001, 14'h1, 14'h3FFE, 14'h1, 14'h0001, 14'h3FFE};
    tbl[5] = '{3'd7, 1'b0, 14'h0010, 14'h0, 14'h0000, 14'h1, 14'h0010, 14'h0007};
    tbl[6] = '{3'd2, 1'b1, 14'h0000, 14'h1, 14'h2000, 14'h0, 14'h2001, 14'h0000};

    sys_rst = 1'b1; en = 1'b0; fmt_twos = 1'b0; dec_log2 = '0;
    ad_data = '0; ad_of = '0; of_clr = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_of", 32'(m_of), 0);
    chk("rst_sticky", 32'(of_sticky), 0);
    chk("rst_overflow", 32'(overflow), 0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // latency of a single sample at dec_log2=0
    en = 1'b1; dec_log2 = 3'd0; fmt_twos = 1'b0;
    ad_data = {14'h0ABC, 14'h1234};
    @(posedge sys_clk);
    @(negedge sys_clk); en = 1'b0;
    @(posedge sys_clk); #1 chk("lat_k1_valid", 32'(m_valid), 0);
    @(posedge sys_clk); #1 chk("lat_k2_valid", 32'(m_valid), 1);
    chk("lat_k2_data", 32'(m_data), {4'h0, 14'h0ABC, 14'h1234});
    repeat (3) @(negedge sys_clk);

    // table-driven windows
    mon_en = 1;
    for (int i = 0; i < 7; i++) begin
      q.push_back('{{tbl[i].e1, tbl[i].e0}, 2'b00});
      drive_window(tbl[i].d, tbl[i].f, tbl[i].b0, tbl[i].s0,
                   tbl[i].b1, tbl[i].s1, -1, 2'b00);
    end
    // window cut short by en falling is discarded
    for (int i = 0; i < 2; i++) begin
      step(); en = 1'b1; dec_log2 = 3'd2; fmt_twos = 1'b0;
      ad_data = {14'h0200, 14'h0200};
    end
    step(); en = 1'b0;
    step();
    q.push_back('{{14'h0050, 14'h0050}, 2'b00});
    drive_window(3'd2, 1'b0, 14'h0050, 14'h0, 14'h0050, 14'h0, -1, 2'b00);
    repeat (4) step();
    chk("tbl_queue_empty", 32'(q.size()), 0);
    mon_en = 0;

    // backpressure: first result held, later ones dropped
    m_ready = 1'b0;
    @(negedge sys_clk); en = 1'b1; dec_log2 = 3'd0; fmt_twos = 1'b0;
    ad_data = {14'h0222, 14'h0111};
    @(negedge sys_clk); ad_data = {14'h0444, 14'h0333};
    @(negedge sys_clk); ad_data = {14'h0666, 14'h0555};
    @(negedge sys_clk); en = 1'b0;
    chk("bp_hold_valid_a", 32'(m_valid), 1);
    chk("bp_hold_data_a", 32'(m_data), {4'h0, 14'h0222, 14'h0111});
    repeat (3) @(negedge sys_clk);
    chk("bp_hold_valid", 32'(m_valid), 1);
    chk("bp_hold_data", 32'(m_data), {4'h0, 14'h0222, 14'h0111});
    chk("bp_overflow", 32'(overflow), 1);
    m_ready = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("bp_drained", 32'(m_valid), 0);
    chk("bp_overflow_sticky", 32'(overflow), 1);
    of_clr = 1'b1;
    @(negedge sys_clk); of_clr = 1'b0;
    chk("bp_overflow_clr", 32'(overflow), 0);

    // out-of-range pulse mid-window
    mon_en = 1;
    q.push_back('{{14'h0100, 14'h0100}, 2'b10});
    drive_window(3'd3, 1'b0, 14'h0100, 14'h0, 14'h0100, 14'h0, 3, 2'b10);
    q.push_back('{{14'h0100, 14'h0100}, 2'b00});
    drive_window(3'd3, 1'b0, 14'h0100, 14'h0, 14'h0100, 14'h0, -1, 2'b00);
    chk("of_queue_empty", 32'(q.size()), 0);
    chk("of_sticky_set", 32'(of_sticky), 2'b10);
    step(); of_clr = 1'b1;
    step(); of_clr = 1'b0;
    chk("of_sticky_clr", 32'(of_sticky), 0);
    mon_en = 0;

    // reset mid-window while output held
    m_ready = 1'b0;
    @(negedge sys_clk); en = 1'b1; dec_log2 = 3'd0;
    ad_data = {14'h0333, 14'h0333};
    @(negedge sys_clk); en = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst2_pre_valid", 32'(m_valid), 1);
    en = 1'b1; dec_log2 = 3'd2; ad_data = {14'h0100, 14'h0100};
    repeat (2) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1 chk("rst2_valid", 32'(m_valid), 0);
    chk("rst2_data", 32'(m_data), 0);
    chk("rst2_overflow", 32'(overflow), 0);
    @(negedge sys_clk); sys_rst = 1'b0; m_ready = 1'b1;
    mon_en = 1;
    q.push_back('{{14'h0100, 14'h0100}, 2'b00});
    repeat (4) step();
    chk("rst2_no_early", 32'(q.size()), 1);
    en = 1'b0;
    repeat (4) step();
    chk("rst2_queue_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
